// File: rtl/alu_result_collector.sv
// alu_result_collector: tracks destination tags of ops issued to the extended
// ALU, captures the integer result (one cycle later) or FP result (two cycles
// later) and queues completed writebacks in order for the register file.
module alu_result_collector #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      issue_is_fp,
    output logic                      alu_en,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic                      alu_zero,
    input  logic                      alu_overflow,
    input  logic                      alu_carry,
    input  logic                      alu_negative,
    input  logic [DATA_WIDTH-1:0]     fp_result,
    input  logic                      fp_overflow,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [3:0]                wb_flags,
    output logic                      wb_is_fp
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int USED_W  = PTR_W + 2;
    // Entry layout: {rd, data, flags[3:0], is_fp}
    localparam int ENTRY_W = REG_ADDR_WIDTH + DATA_WIDTH + 5;

    logic                      alu_en_reg;
    logic                      fp_bubble_reg;
    logic                      t1_valid_reg;
    logic                      t1_fp_reg;
    logic [REG_ADDR_WIDTH-1:0] t1_rd_reg;
    logic                      t2_valid_reg;
    logic [REG_ADDR_WIDTH-1:0] t2_rd_reg;
    logic [PTR_W-1:0]          wr_ptr_reg;
    logic [PTR_W-1:0]          rd_ptr_reg;
    logic [CNT_W-1:0]          count_reg;
    logic [ENTRY_W-1:0]        fifo_mem [FIFO_DEPTH];

    logic [USED_W-1:0]         used;
    logic                      accept;
    logic                      int_done;
    logic                      fp_done;
    logic                      push;
    logic                      pop;
    logic [ENTRY_W-1:0]        push_entry;
    logic [ENTRY_W-1:0]        head;

    // Credit check, accept, completion and push selection from registered state.
    always_comb begin
        used = USED_W'(count_reg) + USED_W'(t1_valid_reg) + USED_W'(t2_valid_reg);
        // Gating on alu_en_reg keeps ops from being accepted while the ALU is
        // still disabled coming out of reset.
        issue_ready = !rst && alu_en_reg && !fp_bubble_reg && (used < USED_W'(FIFO_DEPTH));
        accept      = issue_valid && issue_ready;
        int_done    = t1_valid_reg && !t1_fp_reg;
        fp_done     = t2_valid_reg;
        // rd==0 tags complete silently; nothing is pushed in a reset cycle.
        push = !rst && ((int_done && (t1_rd_reg != '0)) || (fp_done && (t2_rd_reg != '0)));
        if (fp_done) begin
            push_entry = {t2_rd_reg, fp_result, 2'b00, fp_overflow, (fp_result == '0), 1'b1};
        end else begin
            push_entry = {t1_rd_reg, alu_result, alu_negative, alu_carry, alu_overflow,
                          alu_zero, 1'b0};
        end
        wb_valid = (count_reg != '0);
        pop      = wb_valid && wb_ready;
        head     = wb_valid ? fifo_mem[rd_ptr_reg] : '0;
    end

    assign alu_en   = alu_en_reg;
    assign wb_rd    = head[ENTRY_W-1 -: REG_ADDR_WIDTH];
    assign wb_data  = head[DATA_WIDTH+4:5];
    assign wb_flags = head[4:1];
    assign wb_is_fp = head[0];

    // ALU enable, FP issue bubble and the two-stage tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_en_reg    <= 1'b0;
            fp_bubble_reg <= 1'b0;
            t1_valid_reg  <= 1'b0;
            t1_fp_reg     <= 1'b0;
            t1_rd_reg     <= '0;
            t2_valid_reg  <= 1'b0;
            t2_rd_reg     <= '0;
        end else begin
            alu_en_reg    <= 1'b1;
            fp_bubble_reg <= accept && issue_is_fp;
            t1_valid_reg  <= accept;
            t1_fp_reg     <= issue_is_fp;
            t1_rd_reg     <= issue_rd;
            // Integer tags retire in T1; only FP tags occupy T2.
            t2_valid_reg  <= t1_valid_reg && t1_fp_reg;
            t2_rd_reg     <= t1_rd_reg;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage; contents need no reset since wb_* are masked by wb_valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= push_entry;
    end

    // Credit accounting should make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_reg == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: directed steps followed by
// random traffic, checked against an op-level occupancy/ordering model.
module tb_alu_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rd;
    logic        issue_is_fp;
    logic        alu_en;
    logic [31:0] alu_result;
    logic        alu_zero, alu_overflow, alu_carry, alu_negative;
    logic [31:0] fp_result;
    logic        fp_overflow;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  wb_flags;
    logic        wb_is_fp;

    alu_result_collector dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rd(issue_rd), .issue_is_fp(issue_is_fp),
        .alu_en(alu_en),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry(alu_carry), .alu_negative(alu_negative),
        .fp_result(fp_result), .fp_overflow(fp_overflow),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_flags(wb_flags), .wb_is_fp(wb_is_fp)
    );

    always #5 clk = ~clk;

    localparam int MAXOPS = 2048;
    localparam int NEVER  = 1 << 30;
    localparam int DEPTH  = 4;

    // Per-op record: accept cycle, cycle its slot is freed, and its payload.
    int          op_acc   [MAXOPS];
    int          op_rel   [MAXOPS];
    logic [4:0]  op_rd    [MAXOPS];
    bit          op_fp    [MAXOPS];
    logic [31:0] op_data  [MAXOPS];
    logic [3:0]  op_flags [MAXOPS];

    int exp_q[$];          // ids of ops that will be written back, issue order
    int acc_id_at[4];      // id accepted in cycle c stored at c%4, else -1
    int n_ops = 0;
    int base = 0;
    int cyc = 4;
    int last_acc_cyc = -10;
    bit last_acc_fp = 1'b0;
    bit prev_rst = 1'b1;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_flags(input int id);
        if (op_fp[id]) return {2'b00, op_flags[id][1], (op_data[id] == 32'd0)};
        return op_flags[id];
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, clock, update.
    task automatic step(input bit r, input bit v, input logic [4:0] rd, input bit fp,
                        input bit wr, input bit use_d, input logic [31:0] dd,
                        input logic [3:0] df);
        int  id1, id2, occ, hid, nid;
        bit  exp_ready, exp_valid, accept, pop;
        rst = r; issue_valid = v; issue_rd = rd; issue_is_fp = fp; wb_ready = wr;
        id1 = acc_id_at[(cyc - 1) % 4];
        id2 = acc_id_at[(cyc - 2) % 4];
        alu_result = $urandom;
        {alu_negative, alu_carry, alu_overflow, alu_zero} = 4'($urandom);
        if (id1 >= 0 && !op_fp[id1]) begin
            alu_result = op_data[id1];
            {alu_negative, alu_carry, alu_overflow, alu_zero} = op_flags[id1];
        end
        fp_result = $urandom;
        fp_overflow = 1'($urandom);
        if (id2 >= 0 && op_fp[id2]) begin
            fp_result = op_data[id2];
            fp_overflow = op_flags[id2][1];
        end
        #1;
        occ = 0;
        for (int i = base; i < n_ops; i++)
            if (op_acc[i] < cyc && cyc < op_rel[i]) occ++;
        exp_ready = !r && !prev_rst && (occ < DEPTH) &&
                    !(last_acc_cyc == cyc - 1 && last_acc_fp);
        chk("issue_ready", issue_ready, exp_ready);
        chk("alu_en", alu_en, !prev_rst);
        hid = -1;
        if (exp_q.size() > 0) begin
            hid = exp_q[0];
            if (op_acc[hid] + (op_fp[hid] ? 3 : 2) > cyc) hid = -1;
        end
        exp_valid = (hid >= 0);
        chk("wb_valid", wb_valid, exp_valid);
        if (exp_valid) begin
            chk("wb_rd", wb_rd, op_rd[hid]);
            chk("wb_data", wb_data, op_data[hid]);
            chk("wb_flags", wb_flags, exp_flags(hid));
            chk("wb_is_fp", wb_is_fp, op_fp[hid]);
        end else if (prev_rst) begin
            chk("rst_wb_fields", {wb_rd, wb_data, wb_flags, wb_is_fp}, 64'd0);
        end
        $display("cyc=%0d rst=%0b iv=%0b rd=%0d fp=%0b ir=%0b wbv=%0b wbr=%0b wb_rd=%0d wb_data=%08h wb_flags=%04b",
                 cyc, r, v, rd, fp, issue_ready, wb_valid, wr, wb_rd, wb_data, wb_flags);
        accept = v && exp_ready;
        pop = !r && exp_valid && wr;
        @(posedge clk); #1;
        if (r) begin
            base = n_ops;
            exp_q.delete();
            for (int i = 0; i < 4; i++) acc_id_at[i] = -1;
            last_acc_cyc = -10;
        end else begin
            if (pop) begin
                op_rel[hid] = cyc + 1;
                void'(exp_q.pop_front());
            end
            acc_id_at[cyc % 4] = -1;
            if (accept) begin
                nid = n_ops++;
                op_acc[nid] = cyc;
                op_rd[nid] = rd;
                op_fp[nid] = fp;
                if (use_d) begin
                    op_data[nid] = dd;
                    op_flags[nid] = df;
                end else begin
                    op_data[nid] = $urandom;
                    if (fp && $urandom_range(0, 3) == 0) op_data[nid] = 32'd0;
                    op_flags[nid] = 4'($urandom);
                end
                if (rd == 5'd0) op_rel[nid] = cyc + (fp ? 3 : 2);
                else begin
                    op_rel[nid] = NEVER;
                    exp_q.push_back(nid);
                end
                acc_id_at[cyc % 4] = nid;
                last_acc_cyc = cyc;
                last_acc_fp = fp;
            end
        end
        prev_rst = r;
        cyc++;
    endtask

    task automatic idle(input bit wr);
        step(1'b0, 1'b0, 5'd0, 1'b0, wr, 1'b0, 32'd0, 4'd0);
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_is_fp = 1'b0; wb_ready = 1'b0;
        alu_result = '0; {alu_negative, alu_carry, alu_overflow, alu_zero} = 4'd0;
        fp_result = '0; fp_overflow = 1'b0;
        for (int i = 0; i < 4; i++) acc_id_at[i] = -1;
        @(posedge clk); #1;

        // Reset, then come out of reset
        step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        idle(1'b1);
        idle(1'b1);

        // Integer op to rd=3, result 5, flags 0000
        step(1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 4'b0000);
        repeat (4) idle(1'b1);

        // FP op to rd=7 followed by an integer op to rd=8 held valid
        step(1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 32'h4040_0000, 4'b0000);
        step(1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0);
        step(1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0);
        repeat (4) idle(1'b1);

        // Fill with wb_ready low, then drain
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 5'($urandom_range(1, 31)), 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        repeat (2) idle(1'b0);
        repeat (8) idle(1'b1);

        // rd=0 write is dropped
        step(1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0);
        repeat (4) idle(1'b1);

        // FP overflow with zero result
        step(1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 32'd0, 4'b0010);
        repeat (5) idle(1'b1);

        // Reset with ops queued and in flight
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 5'($urandom_range(1, 31)), 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
        step(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0);
        repeat (6) idle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 7),
                 1'b0, 32'd0, 4'd0);
        end
        repeat (10) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
